// File: rtl/ir_pkg.sv
// rtl/ir_pkg.sv - shared types, defaults and parameter checks for the IR carrier monitor
package ir_pkg;

   typedef enum logic {CARRIER = 1'b0, NO_CAR = 1'b1} ir_car_state_t;

   localparam int DEF_CH_NUM      = 4;
   localparam int DEF_CNT_W       = 12;
   localparam int DEF_TIMEOUT     = 2048;
   localparam int DEF_HYST        = 2;
   localparam int DEF_SYNC_STAGES = 2;

   // TIMEOUT must be reachable by a saturating CNT_W-bit counter.
   function automatic bit timeout_ok(input int timeout, input int cnt_w);
      return (timeout >= 1) && (longint'(timeout) < (longint'(1) << cnt_w));
   endfunction

endpackage

// File: rtl/ir_car_monitor_if.sv
// rtl/ir_car_monitor_if.sv - IR carrier monitor signal bundle
interface ir_car_monitor_if #(
   parameter int CH_NUM = 4
);
   logic [CH_NUM-1:0] ir_sd_i;
   logic [CH_NUM-1:0] ir_car_care_i;
   logic [CH_NUM-1:0] ir_car_en_o;
   logic [CH_NUM-1:0] ir_car_chg_o;

   modport master (
      output ir_sd_i,
      output ir_car_care_i,
      input  ir_car_en_o,
      input  ir_car_chg_o
   );

   modport slave (
      input  ir_sd_i,
      input  ir_car_care_i,
      output ir_car_en_o,
      output ir_car_chg_o
   );
endinterface

// File: rtl/ir_car_chan.sv
// rtl/ir_car_chan.sv - one IR channel: synchroniser, gap counter, hysteresis FSM
module ir_car_chan
   import ir_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int TIMEOUT     = DEF_TIMEOUT,
   parameter int HYST        = DEF_HYST,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic ir_sd,
   output logic no_car,
   output logic chg
);

   localparam int              HW     = $clog2(HYST + 1);
   localparam logic [HW-1:0]    H_LAST = HW'(HYST - 1);
   localparam logic [CNT_W-1:0] T_MAX  = CNT_W'(TIMEOUT);

   if (!timeout_ok(TIMEOUT, CNT_W) || HYST < 1 || SYNC_STAGES < 2) begin : g_bad_params
      $error("ir_car_chan: illegal TIMEOUT/CNT_W/HYST/SYNC_STAGES combination");
   end

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic [CNT_W-1:0]       gap_q;
   logic [HW-1:0]          hcnt_q, hcnt_d;
   ir_car_state_t          state_q, state_d;
   logic                   chg_q, chg_d;
   logic                   sd_edge;
   logic                   is_long;

   assign sd_edge = sync_q[SYNC_STAGES-1] ^ hist_q;
   assign is_long = (gap_q == T_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         hist_q <= 1'b0;
         gap_q  <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], ir_sd};
         hist_q <= sync_q[SYNC_STAGES-1];
         if (sd_edge)
            gap_q <= '0;
         else if (gap_q != T_MAX)
            gap_q <= gap_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= CARRIER;
         hcnt_q  <= '0;
         chg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hcnt_q  <= hcnt_d;
         chg_q   <= chg_d;
      end
   end

   // A gap of the class opposite to the current state counts toward a switch;
   // a gap agreeing with the current state restarts the count.
   always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      chg_d   = 1'b0;
      if (sd_edge) begin
         case (state_q)
            CARRIER: begin
               if (is_long) begin
                  if (hcnt_q == H_LAST) begin
                     state_d = NO_CAR;
                     hcnt_d  = '0;
                     chg_d   = 1'b1;
                  end else begin
                     hcnt_d = hcnt_q + 1'b1;
                  end
               end else begin
                  hcnt_d = '0;
               end
            end
            NO_CAR: begin
               if (!is_long) begin
                  if (hcnt_q == H_LAST) begin
                     state_d = CARRIER;
                     hcnt_d  = '0;
                     chg_d   = 1'b1;
                  end else begin
                     hcnt_d = hcnt_q + 1'b1;
                  end
               end else begin
                  hcnt_d = '0;
               end
            end
            default: begin
               state_d = CARRIER;
               hcnt_d  = '0;
            end
         endcase
      end
   end

   assign no_car = (state_q == NO_CAR);
   assign chg    = chg_q;

endmodule

// File: rtl/ir_car_monitor.sv
// rtl/ir_car_monitor.sv - multi-channel IR carrier-presence monitor top
module ir_car_monitor
   import ir_pkg::*;
#(
   parameter int CH_NUM      = DEF_CH_NUM,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int TIMEOUT     = DEF_TIMEOUT,
   parameter int HYST        = DEF_HYST,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input logic             clk,
   input logic             rst,
   ir_car_monitor_if.slave bus
);

   logic [CH_NUM-1:0] no_car_w;
   logic [CH_NUM-1:0] chg_w;

   for (genvar i = 0; i < CH_NUM; i++) begin : g_chan
      ir_car_chan #(
         .CNT_W       (CNT_W),
         .TIMEOUT     (TIMEOUT),
         .HYST        (HYST),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_chan (
         .clk    (clk),
         .rst    (rst),
         .ir_sd  (bus.ir_sd_i[i]),
         .no_car (no_car_w[i]),
         .chg    (chg_w[i])
      );
   end

   // Care gating is purely combinational so mask changes act in the same cycle.
   assign bus.ir_car_en_o  = no_car_w & bus.ir_car_care_i;
   assign bus.ir_car_chg_o = chg_w;

endmodule

// File: tb/tb_ir_car_monitor.sv
// tb/tb_ir_car_monitor.sv - directed self-checking bench for ir_car_monitor
module tb_ir_car_monitor;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   ir_car_monitor_if #(.CH_NUM(4)) bus_a ();
   ir_car_monitor_if #(.CH_NUM(4)) bus_b ();

   ir_car_monitor #(.CH_NUM(4), .CNT_W(12), .TIMEOUT(2048), .HYST(2), .SYNC_STAGES(2)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   ir_car_monitor #(.CH_NUM(4), .CNT_W(12), .TIMEOUT(2048), .HYST(1), .SYNC_STAGES(2)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   int errors = 0;
   int checks = 0;
   int lag_a  = 0;
   int lag_b  = 0;
   int pulses_a [4] = '{0, 0, 0, 0};
   int pulses_b [4] = '{0, 0, 0, 0};

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (bus_a.ir_car_chg_o[i]) pulses_a[i]++;
         if (bus_b.ir_car_chg_o[i]) pulses_b[i]++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      lag_a += n;
      lag_b += n;
   endtask

   // g = edge-free cycles between the previous edge and this one (gap_cnt at the edge)
   task automatic edge_a(input logic [3:0] m, input int g);
      int n;
      n = g + 1 - lag_a;
      if (n < 0) n = 0;
      tick(n);
      bus_a.ir_sd_i ^= m;
      lag_a = 0;
   endtask

   task automatic edge_b(input logic [3:0] m, input int g);
      int n;
      n = g + 1 - lag_b;
      if (n < 0) n = 0;
      tick(n);
      bus_b.ir_sd_i ^= m;
      lag_b = 0;
   endtask

   initial begin
      rst = 1'b1;
      bus_a.ir_sd_i       = 4'b0000;
      bus_a.ir_car_care_i = 4'b1111;
      bus_b.ir_sd_i       = 4'b0000;
      bus_b.ir_car_care_i = 4'b1111;
      tick(3);
      check("rst_en_a", bus_a.ir_car_en_o, 4'b0000);
      check("rst_chg_a", bus_a.ir_car_chg_o, 4'b0000);
      check("rst_en_b", bus_b.ir_car_en_o, 4'b0000);
      rst = 1'b0;
      lag_a = 0;
      lag_b = 0;

      // short toggling never declares no-carrier
      for (int i = 0; i < 5; i++) edge_a(4'b0001, 99);
      tick(4);
      check("short_en", bus_a.ir_car_en_o, 4'b0000);
      check("short_pulses", pulses_a[0], 0);

      // two long gaps with HYST=2
      edge_a(4'b0001, 3000);
      tick(3);
      check("one_long_en", bus_a.ir_car_en_o, 4'b0000);
      edge_a(4'b0001, 3000);
      tick(2);
      check("lat_pre_en", bus_a.ir_car_en_o, 4'b0000);
      check("lat_pre_chg", bus_a.ir_car_chg_o, 4'b0000);
      tick(1);
      check("lat_en", bus_a.ir_car_en_o, 4'b0001);
      check("lat_chg", bus_a.ir_car_chg_o, 4'b0001);
      tick(1);
      check("lat_chg_drop", bus_a.ir_car_chg_o, 4'b0000);
      check("lat_pulses", pulses_a[0], 1);

      // long, short, long, short, short: only the fifth edge returns to carrier
      edge_a(4'b0001, 3000);
      tick(3);
      check("hy_e1", bus_a.ir_car_en_o, 4'b0001);
      edge_a(4'b0001, 50);
      tick(3);
      check("hy_e2", bus_a.ir_car_en_o, 4'b0001);
      edge_a(4'b0001, 3000);
      tick(3);
      check("hy_e3", bus_a.ir_car_en_o, 4'b0001);
      edge_a(4'b0001, 50);
      tick(3);
      check("hy_e4", bus_a.ir_car_en_o, 4'b0001);
      edge_a(4'b0001, 50);
      tick(3);
      check("hy_e5_en", bus_a.ir_car_en_o, 4'b0000);
      check("hy_e5_chg", bus_a.ir_car_chg_o, 4'b0001);
      tick(1);
      check("hy_pulses", pulses_a[0], 2);

      // channels 0 and 3 together, care masks channel 3
      bus_a.ir_car_care_i = 4'b0001;
      edge_a(4'b1001, 3000);
      tick(3);
      check("sim_e1_en", bus_a.ir_car_en_o, 4'b0000);
      edge_a(4'b1001, 3000);
      tick(3);
      check("sim_en", bus_a.ir_car_en_o, 4'b0001);
      check("sim_chg", bus_a.ir_car_chg_o, 4'b1001);
      bus_a.ir_car_care_i = 4'b1001;
      #1;
      check("care_same_cycle", bus_a.ir_car_en_o, 4'b1001);
      tick(1);
      check("sim_pulses3", pulses_a[3], 1);

      // channel 1 into no-carrier, then one short gap (hcnt=1), then reset
      bus_a.ir_car_care_i = 4'b1111;
      edge_a(4'b0010, 3000);
      tick(3);
      edge_a(4'b0010, 3000);
      tick(3);
      check("ch1_nocar_en", bus_a.ir_car_en_o, 4'b1011);
      edge_a(4'b0010, 50);
      tick(3);
      check("ch1_hcnt1_en", bus_a.ir_car_en_o, 4'b1011);
      check("ch1_hcnt1_chg", bus_a.ir_car_chg_o, 4'b0000);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_en", bus_a.ir_car_en_o, 4'b0000);
      check("async_rst_chg", bus_a.ir_car_chg_o, 4'b0000);
      tick(2);
      rst = 1'b0;
      lag_a = 0;
      lag_b = 0;
      edge_a(4'b0010, 3000);
      tick(3);
      check("post_rst_en", bus_a.ir_car_en_o, 4'b0000);
      tick(1);
      check("post_rst_pulses1", pulses_a[1], 1);

      // HYST=1 boundary: 2047 short, 2048 long
      edge_b(4'b0001, 3000);
      tick(3);
      check("b_long_en", bus_b.ir_car_en_o, 4'b0001);
      check("b_long_chg", bus_b.ir_car_chg_o, 4'b0001);
      edge_b(4'b0001, 10);
      tick(3);
      check("b_short_en", bus_b.ir_car_en_o, 4'b0000);
      edge_b(4'b0001, 2047);
      tick(3);
      check("b_2047_en", bus_b.ir_car_en_o, 4'b0000);
      check("b_2047_chg", bus_b.ir_car_chg_o, 4'b0000);
      edge_b(4'b0001, 2048);
      tick(3);
      check("b_2048_en", bus_b.ir_car_en_o, 4'b0001);
      check("b_2048_chg", bus_b.ir_car_chg_o, 4'b0001);
      tick(1);
      check("b_pulses", pulses_b[0], 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ir_car_monitor.md
# ir_car_monitor

Multi-channel, parametrised IR carrier-presence monitor for the IR receive front end. Each channel synchronises a raw demodulator input and measures the gap between transitions. Once a configurable number of consecutive gaps are long, the channel declares that no carrier is present, with hysteresis in both directions. Per-channel results are gated by a care mask, and every state change is reported as a one-cycle pulse for the control CPLD logic.

## Interface
Parameters:
- CH_NUM, 4: number of independent IR channels.
- CNT_W, 12: gap counter width.
- TIMEOUT, 2048: gap length in clk cycles at or above which a gap is classed long. Must be ≥1 and ≤ 2^CNT_W − 1.
- HYST, 2: consecutive same-class gaps required to change state. Must be ≥1. HYST=1 gives single-gap decisions.
- SYNC_STAGES, 2: input synchroniser depth. Must be ≥2.

Ports:
- clk  in  1  system clock (25 MHz nominal).
- rst  in  1  reset. Asynchronous, active-high.
- ir_sd_i  in  CH_NUM  raw IR demodulator inputs, asynchronous to clk.
- ir_car_care_i  in  CH_NUM  per-channel enable mask, synchronous to clk.
- ir_car_en_o  out  CH_NUM  per-channel no-carrier flag ANDed with ir_car_care_i. Combinational from registered state and the care input.
- ir_car_chg_o  out  CH_NUM  one-cycle pulse when a channel's internal no-carrier state toggles. Not gated by care.

## Operation
- Channels are fully independent. Simultaneous events on different channels do not interact.
- Synchroniser: SYNC_STAGES flops, followed by one history flop. edge = last sync stage XOR history flop.
- Gap counter gap_cnt[CNT_W]:
  - Cleared to 0 on edge.
  - Otherwise increments, saturating at TIMEOUT. It never wraps.
- Edge classification uses the gap_cnt value before it is cleared:
  - long if gap_cnt == TIMEOUT, else short.
  - An edge in the exact cycle gap_cnt first reaches TIMEOUT is long.
- Hysteresis counter hcnt, width $clog2(HYST+1), resets to 0.
- State machine, states CARRIER (null=0, reset state) and NO_CAR (null=1):
  - CARRIER, long edge: if hcnt == HYST−1, go to NO_CAR, clear hcnt, pulse chg. Otherwise increment hcnt.
  - CARRIER, short edge: clear hcnt.
  - NO_CAR, short edge: if hcnt == HYST−1, go to CARRIER, clear hcnt, pulse chg. Otherwise increment hcnt.
  - NO_CAR, long edge: clear hcnt.
  - No edge: hold state and hcnt.
- A constant idle input never changes state. A decision requires an edge.
- ir_car_en_o[i] = (state_i == NO_CAR) && ir_car_care_i[i]. Changing the care input affects the output in the same cycle but does not change internal state.

## Timing
- Reset values: all sync and history flops 0, gap_cnt 0, hcnt 0, state CARRIER, ir_car_en_o 0, ir_car_chg_o 0.
- An input held high through reset produces one edge after reset, classed short. It only clears hcnt.
- Latency: an input transition first sampled at rising edge k gives edge=1 in the cycle after edge k+SYNC_STAGES−1. The state, hcnt and chg pulse register at edge k+SYNC_STAGES, i.e. SYNC_STAGES+1 clocks after the first sampling edge.
- ir_car_chg_o is high for exactly one cycle and is coincident with the first cycle of the new state.
- Minimum decision time: HYST edges. Back-to-back edges (1-cycle gaps) are legal and classified short.
- Asserting rst mid-operation immediately returns all outputs to their reset values. No pulse is emitted on reset.

## Structure
- Package ir_pkg holds:
  - typedef enum logic {CARRIER, NO_CAR} ir_car_state_t.
  - Default parameter constants.
  - A function checking TIMEOUT < 2^CNT_W, used in an elaboration assertion.
- Sub-module ir_car_chan implements one channel: synchroniser, gap counter, hysteresis counter and FSM.
- The top level instantiates CH_NUM copies in a generate loop and applies the care gating.

## Test plan
- Reset, then ch0 toggling every 100 cycles with care=1111 → ir_car_en_o stays 0000 and ir_car_chg_o never pulses.
- ch0 toggles at gaps 3000, 3000 (HYST=2) → after the second edge, state goes NO_CAR, ir_car_chg_o[0] pulses once, and ir_car_en_o[0] rises SYNC_STAGES+1 clocks after that edge is sampled. After the first edge alone, the output stays 0.
- From NO_CAR, gaps 3000, 50, 3000, 50, 50 → the output stays 1 until the fifth edge. The interleaved long gap resets the hysteresis count.
- Boundary: gap of exactly TIMEOUT=2048 cycles classed long; 2047 classed short. Check with HYST=1 (1 chg pulse vs none).
- Channels 0 and 3 reach NO_CAR simultaneously with care=0001 → ir_car_en_o=0001 and ir_car_chg_o=1001. Raising care[3] gives 1001 in the same cycle.
- Assert rst while ch1 is in NO_CAR with hcnt=1 → all outputs are 0 asynchronously. After release, a single long edge does not change state (hcnt was cleared).
